// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and memory buses around mem_arbiter.
// slave is the arbiter's view; master is the requesters' and memory's view.
interface mem_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [DATA_W-1:0] if_addr_i;
  logic              if_ack_o;
  logic [DATA_W-1:0] if_rdata_o;

  logic              dm_req_i;
  logic              dm_we_i;
  logic [DATA_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic              dm_ack_o;
  logic [DATA_W-1:0] dm_rdata_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  logic              stall_o;
  logic              timeout_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  mem_ack_i, mem_rdata_i,
    output if_ack_o, if_rdata_o,
    output dm_ack_o, dm_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output stall_o, timeout_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output mem_ack_i, mem_rdata_i,
    input  if_ack_o, if_rdata_o,
    input  dm_ack_o, dm_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  stall_o, timeout_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single-port memory with wait timeout.
// Define MEM_ARB_RR_EN to alternate the tie-break after data grants; default: data always wins ties.
module mem_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DM_BUSY = 2'd1,
    IF_BUSY = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              rdy_q;
  logic              grant_dm;
  logic              grant_if;
  logic              done;
  logic              dm_pend;
  logic              if_pend;
  logic              fetch_first;

  logic              vld_p1;
  logic              we_p1;
  logic [DATA_W-1:0] addr_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic [7:0]        wait_cnt_p1;
  logic              timeout_q;

  logic              if_ack_p2;
  logic              dm_ack_p2;
  logic [DATA_W-1:0] if_rdata_p2;
  logic [DATA_W-1:0] dm_rdata_p2;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A requester whose ack is pulsing this cycle is finished; its req may still be high.
  assign dm_pend = bus.dm_req_i & ~dm_ack_p2;
  assign if_pend = bus.if_req_i & ~if_ack_p2;

`ifdef MEM_ARB_RR_EN
  logic dm_pri_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      dm_pri_q <= 1'b1;
    end else if (grant_dm) begin
      dm_pri_q <= 1'b0;
    end else if (grant_if && dm_pend) begin
      dm_pri_q <= 1'b1;
    end
  end

  assign fetch_first = ~dm_pri_q;
`else
  assign fetch_first = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_dm = 1'b0;
    grant_if = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rdy_q) begin
          if (dm_pend && !(if_pend && fetch_first)) begin
            grant_dm = 1'b1;
            state_d  = DM_BUSY;
          end else if (if_pend) begin
            grant_if = 1'b1;
            state_d  = IF_BUSY;
          end
        end
      end
      DM_BUSY, IF_BUSY: begin
        if (bus.mem_ack_i) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // rdy_q holds off the first grant for one edge after reset release.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
    end
  end

  assign vld_p1 = (state_q != IDLE);

  // Stage p1: granted transaction held stable on the memory bus until ack
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      we_p1    <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
    end else if (grant_dm) begin
      we_p1    <= bus.dm_we_i;
      addr_p1  <= bus.dm_addr_i;
      wdata_p1 <= bus.dm_wdata_i;
    end else if (grant_if) begin
      we_p1    <= 1'b0;
      addr_p1  <= bus.if_addr_i;
    end else if (done) begin
      we_p1    <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wait_cnt_p1 <= 8'd0;
      timeout_q   <= 1'b0;
    end else begin
      if (grant_dm || grant_if) begin
        wait_cnt_p1 <= 8'd0;
      end else if (vld_p1 && !bus.mem_ack_i) begin
        wait_cnt_p1 <= sat_inc(wait_cnt_p1);
      end
      // Flag rises on the same edge the count reaches 255; the transaction keeps waiting.
      if (vld_p1 && !bus.mem_ack_i && (sat_inc(wait_cnt_p1) == 8'hFF)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // Stage p2: ack pulse and captured read data toward the owner
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      if_ack_p2   <= 1'b0;
      dm_ack_p2   <= 1'b0;
      if_rdata_p2 <= '0;
      dm_rdata_p2 <= '0;
    end else begin
      if_ack_p2 <= done && (state_q == IF_BUSY);
      dm_ack_p2 <= done && (state_q == DM_BUSY);
      if (done && (state_q == IF_BUSY)) begin
        if_rdata_p2 <= bus.mem_rdata_i;
      end
      if (done && (state_q == DM_BUSY) && !we_p1) begin
        dm_rdata_p2 <= bus.mem_rdata_i;
      end
    end
  end

  assign bus.mem_req_o   = vld_p1;
  assign bus.mem_we_o    = we_p1;
  assign bus.mem_addr_o  = addr_p1;
  assign bus.mem_wdata_o = wdata_p1;

  assign bus.if_ack_o    = if_ack_p2;
  assign bus.if_rdata_o  = if_rdata_p2;
  assign bus.dm_ack_o    = dm_ack_p2;
  assign bus.dm_rdata_o  = dm_rdata_p2;

  assign bus.stall_o     = dm_pend | if_pend;
  assign bus.timeout_o   = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_arbiter;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // requesters
  bit          dm_want, dm_drop, dm_granted;
  logic        dm_we;
  logic [31:0] dm_addr, dm_wdata;
  bit          if_want, if_drop, if_granted;
  logic [31:0] if_addr;

  // reference model: who owns the memory, what they asked for, what each requester should see
  int          owner;
  logic        own_we;
  logic [31:0] own_addr, own_wdata;
  bit          rdy, fav_fetch, m_timeout, e_dm_ack, e_if_ack;
  int          wait_n;
  logic [31:0] m_if_rdata, m_dm_rdata;

  // memory
  logic [31:0] mem_model [logic [31:0]];
  int          mem_wait, delay_cfg;
  bit          rand_delay, idle_ack_en, rand_mode;

  // observations
  logic [7:0]  ack_log;
  int          dm_ack_n, if_ack_n;
  bit          we_seen;
  logic [31:0] st_addr, st_wdata;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic model_reset();
    owner = 0; rdy = 0; fav_fetch = 0; m_timeout = 0; wait_n = 0;
    e_dm_ack = 0; e_if_ack = 0; m_if_rdata = 0; m_dm_rdata = 0;
  endtask

  task automatic model_edge();
    bit cd, cf;
    e_dm_ack = 0;
    e_if_ack = 0;
    if (!rst_i) begin
      model_reset();
      return;
    end
    if (owner != 0) begin
      if (bus.mem_ack_i) begin
        if (owner == 1) begin
          e_dm_ack = 1;
          if (!own_we) m_dm_rdata = bus.mem_rdata_i;
          else mem_model[own_addr] = own_wdata;
        end else begin
          e_if_ack = 1;
          m_if_rdata = bus.mem_rdata_i;
        end
        owner = 0;
      end else begin
        if (wait_n < 255) wait_n++;
        if (wait_n == 255) m_timeout = 1;
      end
    end else if (rdy) begin
      cd = bus.dm_req_i;
      cf = bus.if_req_i;
      if (cd && (!cf || !fav_fetch)) begin
        owner = 1; own_we = bus.dm_we_i; own_addr = bus.dm_addr_i; own_wdata = bus.dm_wdata_i;
        dm_granted = 1;
`ifdef MEM_ARB_RR_EN
        fav_fetch = 1;
`endif
      end else if (cf) begin
        owner = 2; own_we = 0; own_addr = bus.if_addr_i; own_wdata = 0;
        if_granted = 1;
`ifdef MEM_ARB_RR_EN
        if (cd) fav_fetch = 0;
`endif
      end
      if (owner != 0) begin
        wait_n = 0;
        mem_wait = rand_delay ? int'($urandom_range(0, 3)) : delay_cfg;
      end
    end
    rdy = 1;
  endtask

  task automatic compare();
    check_val("mem_req", bus.mem_req_o, owner != 0);
    if (owner != 0) begin
      check_val("mem_addr", bus.mem_addr_o, own_addr);
      check_val("mem_we", bus.mem_we_o, own_we);
      if (own_we) check_val("mem_wdata", bus.mem_wdata_o, own_wdata);
    end else begin
      check_val("mem_we_idle", bus.mem_we_o, 0);
    end
    check_val("dm_ack", bus.dm_ack_o, e_dm_ack);
    check_val("if_ack", bus.if_ack_o, e_if_ack);
    check_val("dm_rdata", bus.dm_rdata_o, m_dm_rdata);
    check_val("if_rdata", bus.if_rdata_o, m_if_rdata);
    check_val("timeout", bus.timeout_o, m_timeout);
  endtask

  task automatic drive();
    bit dm_acked, if_acked;
    dm_acked = bus.dm_ack_o;
    if_acked = bus.if_ack_o;
    if (dm_acked) begin
      dm_want = 0; dm_drop = 0; dm_granted = 0;
      ack_log = {ack_log[5:0], 2'b01}; dm_ack_n++;
    end
    if (if_acked) begin
      if_want = 0; if_drop = 0; if_granted = 0;
      ack_log = {ack_log[5:0], 2'b10}; if_ack_n++;
    end
    if (bus.mem_we_o) begin
      we_seen = 1; st_addr = bus.mem_addr_o; st_wdata = bus.mem_wdata_o;
    end
    if (rand_mode && rst_i) begin
      if (!dm_want && !dm_acked && $urandom_range(0, 2) == 0) begin
        dm_want = 1; dm_we = 1'($urandom_range(0, 1));
        dm_addr = 32'($urandom_range(0, 15)) << 2; dm_wdata = $urandom;
      end
      if (!if_want && !if_acked && $urandom_range(0, 2) == 0) begin
        if_want = 1; if_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if (dm_granted && !dm_drop && $urandom_range(0, 5) == 0) dm_drop = 1;
      if (if_granted && !if_drop && $urandom_range(0, 5) == 0) if_drop = 1;
    end
    bus.dm_req_i   = dm_want && !dm_drop;
    bus.dm_we_i    = dm_drop ? 1'($urandom) : dm_we;
    bus.dm_addr_i  = dm_drop ? $urandom : dm_addr;
    bus.dm_wdata_i = dm_drop ? $urandom : dm_wdata;
    bus.if_req_i   = if_want && !if_drop;
    bus.if_addr_i  = if_drop ? $urandom : if_addr;
    if (!rst_i) begin
      bus.mem_ack_i = 0; bus.mem_rdata_i = $urandom;
    end else if (owner != 0) begin
      if (mem_wait == 0) begin
        bus.mem_ack_i = 1;
        bus.mem_rdata_i = own_we ? $urandom : mem_read(own_addr);
      end else begin
        bus.mem_ack_i = 0; bus.mem_rdata_i = $urandom; mem_wait--;
      end
    end else begin
      bus.mem_ack_i = idle_ack_en && ($urandom_range(0, 3) == 0);
      bus.mem_rdata_i = $urandom;
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    model_edge();
    compare();
    drive();
    #1;
    check_val("stall", bus.stall_o,
              (bus.dm_req_i && !bus.dm_ack_o) || (bus.if_req_i && !bus.if_ack_o));
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((dm_want || if_want) && n < budget) begin
      step();
      n++;
    end
    check_val("wait_budget", {30'd0, dm_want, if_want}, 32'd0);
  endtask

  task automatic assert_reset();
    rst_i = 0;
    dm_want = 0; dm_drop = 0; dm_granted = 0;
    if_want = 0; if_drop = 0; if_granted = 0;
    bus.dm_req_i = 0; bus.if_req_i = 0; bus.mem_ack_i = 0;
    #1;
    check_val("rst_mem_req", bus.mem_req_o, 0);
    check_val("rst_mem_we", bus.mem_we_o, 0);
    check_val("rst_mem_addr", bus.mem_addr_o, 0);
    check_val("rst_dm_ack", bus.dm_ack_o, 0);
    check_val("rst_if_ack", bus.if_ack_o, 0);
    check_val("rst_timeout", bus.timeout_o, 0);
    check_val("rst_dm_rdata", bus.dm_rdata_o, 0);
    check_val("rst_if_rdata", bus.if_rdata_o, 0);
    model_reset();
  endtask

  task automatic clear_obs();
    ack_log = 0; dm_ack_n = 0; if_ack_n = 0; we_seen = 0; st_addr = 0; st_wdata = 0;
  endtask

  initial begin
    bus.if_req_i = 0; bus.if_addr_i = 0;
    bus.dm_req_i = 0; bus.dm_we_i = 0; bus.dm_addr_i = 0; bus.dm_wdata_i = 0;
    bus.mem_ack_i = 0; bus.mem_rdata_i = 0;
    delay_cfg = 1; rand_delay = 0; idle_ack_en = 0; rand_mode = 0; mem_wait = 0;
    model_reset();
    clear_obs();

    // power-on reset with a fetch already waiting at release
    #2;
    assert_reset();
    repeat (2) step();
    mem_model[32'h10] = 32'h13;
    if_want = 1; if_addr = 32'h10;
    step();
    rst_i = 1;
    wait_done(20);
    check_val("fetch_rdata", bus.if_rdata_o, 32'h13);
    check_val("fetch_acks", if_ack_n, 1);
    check_val("fetch_no_we", we_seen, 0);

    // simultaneous store and fetch
    clear_obs();
    dm_want = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
    if_want = 1; if_addr = 32'h20;
    wait_done(20);
    check_val("tie_order", ack_log, 8'h06);
    check_val("store_addr", st_addr, 32'h100);
    check_val("store_wdata", st_wdata, 32'hDEAD_BEEF);
    check_val("store_keeps_rdata", bus.dm_rdata_o, 0);

    // two back-to-back ties from a fresh reset
    step();
    assert_reset();
    repeat (2) step();
    rst_i = 1;
    step();
    clear_obs();
    dm_want = 1; dm_we = 0; dm_addr = 32'h104; if_want = 1; if_addr = 32'h24;
    wait_done(20);
    dm_want = 1; dm_we = 0; dm_addr = 32'h108; if_want = 1; if_addr = 32'h28;
    wait_done(20);
`ifdef MEM_ARB_RR_EN
    check_val("rr_order", ack_log, 8'h69);
`else
    check_val("fixed_order", ack_log, 8'h66);
`endif

    // memory silent for 300 cycles
    clear_obs();
    delay_cfg = 300;
    if_want = 1; if_addr = 32'h44;
    wait_done(400);
    check_val("timeout_set", bus.timeout_o, 1);
    check_val("late_ack_done", if_ack_n, 1);
    delay_cfg = 1;
    repeat (5) step();
    check_val("timeout_sticky", bus.timeout_o, 1);

    // reset in the middle of a data transaction
    clear_obs();
    delay_cfg = 20;
    dm_want = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'h1234_5678;
    for (int i = 0; i < 10 && owner != 1; i++) step();
    repeat (3) step();
    check_val("pre_rst_busy", bus.mem_req_o, 1);
    #2;
    assert_reset();
    repeat (2) step();
    rst_i = 1;
    delay_cfg = 1;
    if_want = 1; if_addr = 32'h10;
    wait_done(20);
    check_val("post_rst_dm_acks", dm_ack_n, 0);
    check_val("post_rst_fetch", bus.if_rdata_o, 32'h13);

    // random traffic, clear the sticky timeout first
    step();
    assert_reset();
    repeat (2) step();
    rst_i = 1;
    rand_mode = 1; rand_delay = 1; idle_ack_en = 1;
    repeat (3000) step();
    rand_mode = 0;
    wait_done(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
